mc_conunit: RTL

//  Multi-cycle control unit that replaces the single-cycle decoder.

---
 rtl/mc_conunit_if.sv | 21 ++
 rtl/mc_conunit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mc_conunit_if.sv
// mc_conunit_if: IR fields, flags and memory handshakes into the control unit; strobes and mux selects out
interface mc_conunit_if #(
  parameter int OPW   = 6,
  parameter int FUNCW = 6
);
  logic [OPW-1:0]   op;
  logic [FUNCW-1:0] func;
  logic             z, v, imem_rdy, dmem_rdy, intr, ie;
  logic             pcwr, irwr, wreg, wmem, regrt, se, aluqb, reg2reg, wepc, wcau, inta;
  logic [1:0]       aluc, pcsrc;
  logic [4:0]       cause;
  logic [2:0]       state;
  modport master (
    output op, func, z, v, imem_rdy, dmem_rdy, intr, ie,
    input  pcwr, irwr, wreg, wmem, regrt, se, aluqb, reg2reg, wepc, wcau, inta, aluc, pcsrc, cause, state
  );
  modport slave (
    input  op, func, z, v, imem_rdy, dmem_rdy, intr, ie,
    output pcwr, irwr, wreg, wmem, regrt, se, aluqb, reg2reg, wepc, wcau, inta, aluc, pcsrc, cause, state
  );
endinterface

// File: rtl/mc_conunit.sv
// mc_conunit: multi-cycle IF/ID/EX/MEM/WB control FSM with precise exceptions and interrupt acknowledge
module mc_conunit #(
  parameter int OPW     = 6,
  parameter int FUNCW   = 6,
  parameter int TMO     = 15,
  parameter int CNTW    = 4,
  parameter int INTR_EN = 1
) (
  input logic         clk,
  input logic         rst_n,
  mc_conunit_if.slave bus
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_EXC = 3'd5} state_t;
  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [4:0]      cause_q, cause_d;
  logic            pcwr, irwr, wreg, wmem, wepc, wcau, inta;
  logic [1:0]      pcsrc;
  logic rt, i_add, i_sub, i_and, i_or, i_addi, i_andi, i_ori, i_lw, i_sw, i_beq, i_bne, i_j, legal, tmo, irq, taken;
  assign rt     = bus.op == '0;
  assign i_add  = rt && bus.func == FUNCW'(6'b100000);
  assign i_sub  = rt && bus.func == FUNCW'(6'b100010);
  assign i_and  = rt && bus.func == FUNCW'(6'b100100);
  assign i_or   = rt && bus.func == FUNCW'(6'b100101);
  assign i_addi = bus.op == OPW'(6'b001000);
  assign i_andi = bus.op == OPW'(6'b001100);
  assign i_ori  = bus.op == OPW'(6'b001101);
  assign i_lw   = bus.op == OPW'(6'b100011);
  assign i_sw   = bus.op == OPW'(6'b101011);
  assign i_beq  = bus.op == OPW'(6'b000100);
  assign i_bne  = bus.op == OPW'(6'b000101);
  assign i_j    = bus.op == OPW'(6'b000010);
  assign legal  = i_add | i_sub | i_and | i_or | i_addi | i_andi | i_ori | i_lw | i_sw | i_beq | i_bne | i_j;
  assign tmo    = cnt_q == CNTW'(TMO);
  assign irq    = (INTR_EN != 0) && bus.intr && bus.ie;
  assign taken  = (i_beq & bus.z) | (i_bne & ~bus.z);
  assign bus.regrt   = ~rt;
  assign bus.se      = ~(i_andi | i_ori);
  assign bus.aluqb   = i_addi | i_andi | i_ori | i_lw | i_sw;
  assign bus.aluc    = (i_sub | i_beq | i_bne) ? 2'b01 : (i_and | i_andi) ? 2'b10 : (i_or | i_ori) ? 2'b11 : 2'b00;
  assign bus.reg2reg = i_lw;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    {pcwr, irwr, wreg, wmem, wepc, wcau, inta} = '0;
    pcsrc = 2'b00;
    case (state_q)
      S_IF: begin
        if (irq) begin
          state_d = S_EXC;
          cause_d = 5'd0;
        end else if (bus.imem_rdy) begin
          {irwr, pcwr} = 2'b11;
          state_d = S_ID;
        end else if (tmo) begin
          state_d = S_EXC;
          cause_d = 5'd7;
        end
      end
      S_ID: begin
        state_d = i_j ? S_IF : legal ? S_EX : S_EXC;
        cause_d = legal ? cause_q : 5'd10;
        pcwr    = i_j;
        pcsrc   = i_j ? 2'b10 : 2'b00;
      end
      S_EX: begin
        if (i_beq | i_bne) begin
          pcwr    = taken;
          pcsrc   = taken ? 2'b01 : 2'b00;
          state_d = S_IF;
        end else if ((i_add | i_addi) & bus.v) begin
          state_d = S_EXC;
          cause_d = 5'd12;
        end else state_d = (i_lw | i_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        wmem = i_sw & (bus.dmem_rdy | ~tmo);
        if (bus.dmem_rdy) state_d = i_sw ? S_IF : S_WB;
        else if (tmo) begin
          state_d = S_EXC;
          cause_d = 5'd7;
        end
      end
      S_WB: begin
        wreg    = 1'b1;
        state_d = S_IF;
      end
      S_EXC: begin
        {wepc, wcau, pcwr} = 3'b111;
        pcsrc   = 2'b11;
        inta    = (INTR_EN != 0) && cause_q == 5'd0;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
    // only IF and MEM can hold their state, so this counts stall cycles there
    cnt_d = (state_d == state_q) ? cnt_q + CNTW'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end
  // gating with rst_n keeps strobes quiet while reset is held, even in IF with imem_rdy high
  assign bus.pcwr  = rst_n & pcwr;
  assign bus.irwr  = rst_n & irwr;
  assign bus.wreg  = rst_n & wreg;
  assign bus.wmem  = rst_n & wmem;
  assign bus.wepc  = rst_n & wepc;
  assign bus.wcau  = rst_n & wcau;
  assign bus.inta  = rst_n & inta;
  assign bus.pcsrc = pcsrc;
  assign bus.cause = (rst_n && state_q == S_EXC) ? cause_q : 5'd0;
  assign bus.state = state_q;
endmodule
